mips_uc_harness: RTL and testbench

MIPS_UC_HARNESS -- requirements
Module: mips_uc_harness

---
 rtl/mips_uc_pkg.sv | 24 ++
 rtl/mips_uc_run_counter.sv | 34 +++
 rtl/mips_uc_harness.sv | 137 +++++++++++++
 tb/tb_mips_uc_harness.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_uc_pkg.sv
// Shared definitions for the core supervision harness: FSM state
// encoding, parameter defaults and a small sizing helper.
package mips_uc_pkg;

    // Supervisor FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESET   = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int DEF_N_CORES        = 1;
    localparam int DEF_RST_CYCLES     = 4;
    localparam int DEF_CNT_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1000;

    // Bits needed to hold a down-counter loaded with cycles-1 (minimum 1 bit)
    function automatic int rst_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mips_uc_run_counter.sv
// Run cycle counter: synchronous clear, count enable, saturation at all
// ones, and a flag that is high while the count equals TERMINAL.
module mips_uc_run_counter
    import mips_uc_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TERMINAL = DEF_TIMEOUT_CYCLES - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_term
);

    logic [CNT_W-1:0] r_count;
    logic             w_sat;

    assign w_sat = (r_count == {CNT_W{1'b1}});

    // Count register: clear wins over enable, holds once saturated
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_sat) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == CNT_W'(TERMINAL));

endmodule

// File: rtl/mips_uc_harness.sv
// Core supervision harness: holds the cores in reset, releases them for a
// bounded run, records which cores halt, and reports DONE or TIMEOUT.
module mips_uc_harness
    import mips_uc_pkg::*;
#(
    parameter int N_CORES        = DEF_N_CORES,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CORES-1:0] core_halt,
    output logic [N_CORES-1:0] core_rst,
    output logic               run_active,
    output logic               done,
    output logic               timeout,
    output logic [N_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int               RST_W    = rst_cnt_width(RST_CYCLES);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [RST_W-1:0]   r_rst_cnt;
    logic [RST_W-1:0]   w_rst_cnt_next;
    logic [N_CORES-1:0] r_halted_mask;
    logic [N_CORES-1:0] w_halted_next;
    logic [N_CORES-1:0] w_halt_or;
    logic [N_CORES-1:0] r_core_rst;
    logic [N_CORES-1:0] w_core_rst_next;
    logic               r_run_active;
    logic               r_done;
    logic               r_timeout;
    logic               w_all_halted;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_cnt_term;
    logic [CNT_W-1:0]   w_cycle_count;

    // Per-core sticky halt view including this cycle's halt inputs
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_halt
        assign w_halt_or[gi] = r_halted_mask[gi] | core_halt[gi];
    end

    assign w_all_halted = &w_halt_or;

    // Next-state decode; completion is tested before timeout so a tie ends in DONE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RESET;
            end
            ST_RESET: begin
                if (r_rst_cnt == '0) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_all_halted)    w_state_next = ST_DONE;
                else if (w_cnt_term) w_state_next = ST_TIMEOUT;
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start) w_state_next = ST_RESET;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Reset hold counter, halt mask and registered output decode
    always_comb begin
        w_rst_cnt_next = r_rst_cnt;
        w_halted_next  = r_halted_mask;
        if ((w_state_next == ST_RESET) && (r_state != ST_RESET)) begin
            // Entering RESET: start a fresh hold and forget previous halts
            w_rst_cnt_next = RST_LOAD;
            w_halted_next  = '0;
        end else if (r_state == ST_RESET) begin
            if (r_rst_cnt != '0) w_rst_cnt_next = r_rst_cnt - RST_W'(1);
            w_halted_next = '0;
        end else if (r_state == ST_RUN) begin
            // Halts are only recorded while running
            w_halted_next = w_halt_or;
        end

        // Cores run only in RUN, and a halted core is frozen from the next cycle on
        w_core_rst_next = (w_state_next == ST_RUN) ? w_halted_next : '1;

        // Clear on entry to RUN; count only while staying in RUN so the
        // value is frozen at the cycle the run ended
        w_cnt_clr = (r_state == ST_RESET) && (w_state_next == ST_RUN);
        w_cnt_en  = (r_state == ST_RUN)   && (w_state_next == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_rst_cnt     <= '0;
            r_halted_mask <= '0;
            r_core_rst    <= '1;
            r_run_active  <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_rst_cnt     <= w_rst_cnt_next;
            r_halted_mask <= w_halted_next;
            r_core_rst    <= w_core_rst_next;
            r_run_active  <= (w_state_next == ST_RUN);
            r_done        <= (w_state_next == ST_DONE);
            r_timeout     <= (w_state_next == ST_TIMEOUT);
        end
    end

    mips_uc_run_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_run_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cycle_count),
        .o_term  (w_cnt_term)
    );

    assign core_rst    = r_core_rst;
    assign run_active  = r_run_active;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign halted_mask = r_halted_mask;
    assign cycle_count = w_cycle_count;

endmodule

// File: tb/tb_mips_uc_harness.sv
// Bench for mips_uc_harness: directed scenarios with literal expectations,
// then random start/halt/reset traffic, all compared every cycle against
// a phase-level behavioural model.
module tb_mips_uc_harness;

    localparam int N   = 2;
    localparam int RST = 4;
    localparam int TO  = 20;
    localparam int CW  = 8;

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;
    localparam int P_TO   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  core_halt;
    logic [N-1:0]  core_rst;
    logic          run_active;
    logic          done;
    logic          timeout;
    logic [N-1:0]  halted_mask;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    mips_uc_harness #(
        .N_CORES        (N),
        .RST_CYCLES     (RST),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .core_halt   (core_halt),
        .core_rst    (core_rst),
        .run_active  (run_active),
        .done        (done),
        .timeout     (timeout),
        .halted_mask (halted_mask),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase, remaining reset cycles, run count, halt record
    typedef struct {
        int         phase;
        int         rleft;
        int         cnt;
        logic [1:0] mask;
    } mdl_t;

    mdl_t m = '{phase: P_IDLE, rleft: 0, cnt: 0, mask: 2'b00};

    function automatic mdl_t step(mdl_t s, logic r, logic st, logic [1:0] h);
        mdl_t n = s;
        logic [1:0] seen;
        if (r) begin
            n = '{phase: P_IDLE, rleft: 0, cnt: 0, mask: 2'b00};
            return n;
        end
        case (s.phase)
            P_IDLE, P_DONE, P_TO: begin
                if (st) begin
                    n.phase = P_RST;
                    n.rleft = RST - 1;
                    n.mask  = 2'b00;
                end
            end
            P_RST: begin
                n.mask = 2'b00;
                if (s.rleft == 0) begin
                    n.phase = P_RUN;
                    n.cnt   = 0;
                end else begin
                    n.rleft = s.rleft - 1;
                end
            end
            default: begin
                seen   = s.mask | h;
                n.mask = seen;
                if (seen == 2'b11)       n.phase = P_DONE;
                else if (s.cnt == TO-1)  n.phase = P_TO;
                else                     n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
            end
        endcase
        return n;
    endfunction

    function automatic int e_core_rst(mdl_t s);
        return (s.phase == P_RUN) ? int'(s.mask) : 3;
    endfunction

    always @(posedge clk) m <= step(m, rst, start, core_halt);

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (int'(core_rst) != e_core_rst(m) || run_active != (m.phase == P_RUN) ||
                done != (m.phase == P_DONE) || timeout != (m.phase == P_TO) ||
                halted_mask != m.mask || int'(cycle_count) != m.cnt) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got core_rst=%b run=%b done=%b to=%b mask=%b cnt=%0d want core_rst=%0d run=%0d done=%0d to=%0d mask=%b cnt=%0d",
                         $time, core_rst, run_active, done, timeout, halted_mask, cycle_count,
                         e_core_rst(m), m.phase == P_RUN, m.phase == P_DONE, m.phase == P_TO, m.mask, m.cnt);
            end
        end
    end

    // Literal expectation checked against both the DUT and the model
    task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp_v);
        checks++;
        if (dut_v != exp_v) begin
            errors++;
            $display("FAIL %s dut=%0d expected=%0d", name, dut_v, exp_v);
        end
        checks++;
        if (mdl_v != exp_v) begin
            errors++;
            $display("FAIL %s model=%0d expected=%0d", name, mdl_v, exp_v);
        end
    endtask

    // Advance n cycles; inputs change just after the rising edge
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; core_halt = 2'b11;
        go(3);
        check_en = 1'b1;
        rst = 1'b0; core_halt = 2'b00;
        @(negedge clk);
        lit("reset_core_rst", int'(core_rst), e_core_rst(m), 3);
        lit("reset_cnt", int'(cycle_count), m.cnt, 0);
        lit("reset_flags", int'({run_active, done, timeout}), 0, 0);
        $display("txn reset: core_rst=%b mask=%b cnt=%0d", core_rst, halted_mask, cycle_count);

        // Nominal run: start in cycle 0, halts at run cycles 5 and 9
        start = 1'b1; go(1); start = 1'b0;
        go(4);
        @(negedge clk);
        lit("nom_first_run_core_rst", int'(core_rst), e_core_rst(m), 0);
        lit("nom_first_run_cnt", int'(cycle_count), m.cnt, 0);
        go(5); core_halt = 2'b01;
        go(1); core_halt = 2'b00;
        @(negedge clk);
        lit("nom_core0_frozen", int'(core_rst), e_core_rst(m), 1);
        go(3); core_halt = 2'b10;
        go(1); core_halt = 2'b00;
        @(negedge clk);
        lit("nom_done", int'(done), int'(m.phase == P_DONE), 1);
        lit("nom_done_cnt", int'(cycle_count), m.cnt, 9);
        lit("nom_done_mask", int'(halted_mask), int'(m.mask), 3);
        $display("txn nominal: done=%b cnt=%0d mask=%b", done, cycle_count, halted_mask);

        // Restart from DONE, ignored start in RUN, then timeout with core 0 only
        start = 1'b1; go(1); start = 1'b0;
        @(negedge clk);
        lit("restart_mask_cleared", int'(halted_mask), int'(m.mask), 0);
        go(4);
        @(negedge clk);
        lit("restart_run_after_4", int'(run_active), int'(m.phase == P_RUN), 1);
        go(3); start = 1'b1;
        go(1); start = 1'b0;
        @(negedge clk);
        lit("ignored_start_cnt", int'(cycle_count), m.cnt, 4);
        go(1); core_halt = 2'b01;
        go(1); core_halt = 2'b00;
        go(14);
        @(negedge clk);
        lit("to_flag", int'(timeout), int'(m.phase == P_TO), 1);
        lit("to_cnt", int'(cycle_count), m.cnt, 19);
        lit("to_mask", int'(halted_mask), int'(m.mask), 1);
        lit("to_core_rst", int'(core_rst), e_core_rst(m), 3);
        $display("txn timeout: to=%b cnt=%0d mask=%b", timeout, cycle_count, halted_mask);

        // Tie: last halt at cycle_count 19
        start = 1'b1; go(1); start = 1'b0;
        go(7); core_halt = 2'b01;
        go(1); core_halt = 2'b00;
        go(15); core_halt = 2'b10;
        go(1); core_halt = 2'b00;
        @(negedge clk);
        lit("tie_done", int'(done), int'(m.phase == P_DONE), 1);
        lit("tie_timeout", int'(timeout), int'(m.phase == P_TO), 0);
        lit("tie_cnt", int'(cycle_count), m.cnt, 19);
        $display("txn tie: done=%b to=%b cnt=%0d", done, timeout, cycle_count);

        // Reset at cycle_count 7, with start and a halt in the same cycle
        start = 1'b1; go(1); start = 1'b0;
        go(11); rst = 1'b1; start = 1'b1; core_halt = 2'b01;
        go(1); rst = 1'b0; start = 1'b0; core_halt = 2'b11;
        @(negedge clk);
        lit("midrst_core_rst", int'(core_rst), e_core_rst(m), 3);
        lit("midrst_flags", int'({run_active, done, timeout}), 0, 0);
        lit("midrst_cnt", int'(cycle_count), m.cnt, 0);
        lit("midrst_mask", int'(halted_mask), int'(m.mask), 0);
        go(2); core_halt = 2'b00;
        $display("txn midrun_reset: core_rst=%b cnt=%0d", core_rst, cycle_count);

        // Random traffic checked by the every-cycle compare
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 7) == 0);
            core_halt = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
            go(1);
        end
        rst = 1'b0; start = 1'b0; core_halt = 2'b00;
        go(2);
        $display("txn random: 3000 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
